// File: rtl/t05_sram_responder.sv
// Responder end of the team_05 SRAM bus: word-addressed storage serving one
// request at a time with a fixed WAIT latency, byte enables and error reporting.
module t05_sram_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        r_en,
   input  logic [3:0]  select,
   input  logic [31:0] addr,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        busy_o,
   output logic        ack_o,
   output logic        err_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                armed_q, armed_d;
   logic [ADDR_W-1:0]   widx_q, widx_d;
   logic [3:0]          sel_q, sel_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                wr_q, wr_d;
   logic                bad_q, bad_d;
   logic [31:0]         data_q, data_d;
   logic                busy_q, busy_d;
   logic                ack_q, ack_d;
   logic                err_q, err_d;

   logic                req_bad;
   logic [31:0]         byte_mask;
   logic [31:0]         rd_word;

   logic [31:0]         mem [DEPTH_WORDS];

   assign rd_word = mem[widx_q];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      armed_d = armed_q;
      widx_d  = widx_q;
      sel_d   = sel_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      bad_d   = bad_q;
      data_d  = data_q;

      req_bad = (addr >= 32'(4 * DEPTH_WORDS)) || (addr[1:0] != 2'b00) || (r_en && wr_en);

      byte_mask = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         byte_mask[8*i +: 8] = {8{sel_q[i]}};
      end

      // Any idle-enable cycle re-arms, so a held request completes only once.
      if (!r_en && !wr_en) begin
         armed_d = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (armed_q && (r_en || wr_en)) begin
               armed_d = 1'b0;
               widx_d  = addr[ADDR_W+1:2];
               sel_d   = select;
               wdata_d = data_i;
               wr_d    = wr_en;
               bad_d   = req_bad;
               cnt_d   = 4'(LATENCY) - 4'd1;
               state_d = (LATENCY == 0) ? S_ACCESS : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_ACCESS;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACCESS: begin
            state_d = S_RESP;
            if (bad_q) begin
               data_d = '0;
            end else if (!wr_q) begin
               data_d = rd_word & byte_mask;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_WAIT) || (state_d == S_ACCESS);
      ack_d  = (state_d == S_RESP);
      err_d  = (state_d == S_RESP) && bad_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         armed_q <= 1'b1;
         widx_q  <= '0;
         sel_q   <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         bad_q   <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         widx_q  <= widx_d;
         sel_q   <= sel_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         bad_q   <= bad_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // Write lands at the closing edge of ACCESS; a reset on that edge discards it.
   always_ff @(posedge clk) begin
      if (!rst && (state_q == S_ACCESS) && wr_q && !bad_q) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (sel_q[i]) begin
               mem[widx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

   assign data_o = data_q;
   assign busy_o = busy_q;
   assign ack_o  = ack_q;
   assign err_o  = err_q;

endmodule

// File: tb/tb_t05_sram_responder.sv
// Self-checking bench for t05_sram_responder: directed vector table, held-enable
// and reset-abort sequences, then random traffic against a word-array model.
module tb_t05_sram_responder;

   localparam int unsigned LAT    = 2;
   localparam int          ACK_N  = LAT + 2;
   localparam int          BUSY_N = LAT + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic        r_en;
   logic [3:0]  select;
   logic [31:0] addr;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        busy_o;
   logic        ack_o;
   logic        err_o;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   t05_sram_responder #(
      .DEPTH_WORDS (1024),
      .ADDR_W      (10),
      .LATENCY     (LAT)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en),
      .r_en   (r_en),
      .select (select),
      .addr   (addr),
      .data_i (data_i),
      .data_o (data_o),
      .busy_o (busy_o),
      .ack_o  (ack_o),
      .err_o  (err_o)
   );

   typedef struct {
      logic        w;
      logic        r;
      logic [3:0]  sel;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_q;
      logic        exp_e;
   } vec_t;

   vec_t tbl [15];

   logic [31:0] ref_mem [1024];
   logic [31:0] ref_last;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   // One request pulse, then observe 12 cycles after the acceptance edge.
   task automatic txn(input logic w, input logic r, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] q, output logic e,
                      output int ack_at, output int busy_n, output int acks);
      q = '0; e = 1'b0; ack_at = -1; busy_n = 0; acks = 0;
      @(posedge clk); #1;
      wr_en = w; r_en = r; select = s; addr = a; data_i = d;
      @(posedge clk); #1;
      wr_en = 1'b0; r_en = 1'b0;
      addr = $urandom; data_i = $urandom; select = 4'($urandom);
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (busy_o) busy_n++;
         if (ack_o) begin
            acks++;
            if (ack_at < 0) begin
               ack_at = n;
               q = data_o;
               e = err_o;
            end
         end
      end
   endtask

   task automatic run_chk(input string nm, input logic w, input logic r, input logic [3:0] s,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_q, input logic exp_e);
      logic [31:0] q;
      logic        e;
      int          ack_at, busy_n, acks;
      txn(w, r, s, a, d, q, e, ack_at, busy_n, acks);
      check({nm, ".ack_cycle"}, 32'(ack_at), 32'(ACK_N));
      check({nm, ".busy_cycles"}, 32'(busy_n), 32'(BUSY_N));
      check({nm, ".ack_count"}, 32'(acks), 32'd1);
      check({nm, ".err"}, 32'(e), 32'(exp_e));
      check({nm, ".data"}, q, exp_q);
   endtask

   // Reference: a flat word array updated by byte enables, plus the last response word.
   task automatic model(input logic w, input logic r, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] exp_q, output logic exp_e);
      logic [31:0] word;
      exp_e = (a >= 32'h1000) || (a % 4 != 0) || (w && r);
      if (exp_e) begin
         exp_q = '0;
      end else begin
         word = ref_mem[a / 4];
         if (r) begin
            exp_q = '0;
            for (int i = 0; i < 4; i++)
               if (s[i]) exp_q[8*i +: 8] = word[8*i +: 8];
         end else begin
            for (int i = 0; i < 4; i++)
               if (s[i]) word[8*i +: 8] = d[8*i +: 8];
            ref_mem[a / 4] = word;
            exp_q = ref_last;
         end
      end
      ref_last = exp_q;
   endtask

   initial begin
      int acks;
      logic [31:0] pool [12];

      rst = 1'b1; wr_en = 1'b0; r_en = 1'b0; select = '0; addr = '0; data_i = '0;

      tbl[0]  = '{1'b1, 1'b0, 4'hF,    32'h400,  32'hDEADBEEF, 32'h00000000, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 4'hF,    32'h400,  32'h0,        32'hDEADBEEF, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 4'b0101, 32'h400,  32'h0,        32'h00AD00EF, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 4'b1000, 32'h400,  32'h11000000, 32'h00AD00EF, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 4'hF,    32'h400,  32'h0,        32'h11ADBEEF, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 4'hF,    32'h1000, 32'h0,        32'h00000000, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 4'hF,    32'h402,  32'h0,        32'h00000000, 1'b1};
      tbl[7]  = '{1'b1, 1'b1, 4'hF,    32'h400,  32'h12345678, 32'h00000000, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 4'hF,    32'h1000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 4'h0,    32'h400,  32'h55555555, 32'h00000000, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 4'hF,    32'h400,  32'h0,        32'h11ADBEEF, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 4'hF,    32'hFFC,  32'hA5A55A5A, 32'h11ADBEEF, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 4'hF,    32'hFFC,  32'h0,        32'hA5A55A5A, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 4'hF,    32'h0,    32'h01020304, 32'hA5A55A5A, 1'b0};
      tbl[14] = '{1'b0, 1'b1, 4'b1010, 32'h0,    32'h0,        32'h01000300, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset.busy", 32'(busy_o), 32'd0);
      check("reset.ack",  32'(ack_o),  32'd0);
      check("reset.err",  32'(err_o),  32'd0);
      check("reset.data", data_o,      32'd0);
      @(posedge clk); #1 rst = 1'b0;

      for (int i = 0; i < 15; i++)
         run_chk($sformatf("vec%0d", i), tbl[i].w, tbl[i].r, tbl[i].sel, tbl[i].a, tbl[i].d,
                 tbl[i].exp_q, tbl[i].exp_e);

      // r_en held high for 10 cycles: one ack, then one more after a one-cycle drop.
      @(posedge clk); #1;
      r_en = 1'b1; select = 4'hF; addr = 32'h400;
      acks = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (ack_o) acks++;
      end
      check("held.first_acks", 32'(acks), 32'd1);
      @(posedge clk); #1 r_en = 1'b0;
      @(posedge clk); #1 r_en = 1'b1;
      acks = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (ack_o) begin
            acks++;
            check("held.second_data", data_o, 32'h11ADBEEF);
         end
      end
      check("held.second_acks", 32'(acks), 32'd1);
      @(posedge clk); #1 r_en = 1'b0;
      repeat (2) @(posedge clk);

      // Reset during the wait phase of a write must discard it without an ack.
      run_chk("pre800", 1'b1, 1'b0, 4'hF, 32'h800, 32'h11223344, 32'h11ADBEEF, 1'b0);
      @(posedge clk); #1;
      wr_en = 1'b1; select = 4'hF; addr = 32'h800; data_i = 32'hCAFEF00D;
      @(posedge clk); #1 wr_en = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("abort.busy", 32'(busy_o), 32'd0);
      check("abort.data", data_o, 32'd0);
      acks = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (ack_o) acks++;
      end
      check("abort.acks", 32'(acks), 32'd0);
      run_chk("post800", 1'b0, 1'b1, 4'hF, 32'h800, 32'h0, 32'h11223344, 1'b0);

      // Random traffic over a small pool in the three regions.
      for (int k = 0; k < 12; k++) pool[k] = 32'((k / 4) * 1024 + (k % 4) * 4 + 32'h100);
      ref_last = 32'h11223344;
      for (int k = 0; k < 12; k++) begin
         logic [31:0] eq;
         logic        ee;
         logic [31:0] d;
         d = $urandom;
         model(1'b1, 1'b0, 4'hF, pool[k], d, eq, ee);
         run_chk($sformatf("init%0d", k), 1'b1, 1'b0, 4'hF, pool[k], d, eq, ee);
      end
      for (int k = 0; k < 60; k++) begin
         logic        w, r;
         logic [3:0]  s;
         logic [31:0] a, d, eq;
         logic        ee;
         int          op;
         op = $urandom_range(0, 9);
         s  = 4'($urandom);
         d  = $urandom;
         a  = pool[$urandom_range(0, 11)];
         w  = (op >= 7);
         r  = !w;
         if (op == 0) begin
            w = 1'b1; r = 1'b1;
         end else if (op == 1) begin
            a = 32'h1000 + 32'($urandom_range(0, 1000)) * 4;
            w = 1'($urandom); r = !w;
         end else if (op == 2) begin
            a = a + 32'($urandom_range(1, 3));
            w = 1'($urandom); r = !w;
         end
         model(w, r, s, a, d, eq, ee);
         run_chk($sformatf("rnd%0d", k), w, r, s, a, d, eq, ee);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
